// File: rtl/bcd_pkg.sv
// Shared types and constants for the ASCII-to-BCD front end and the BCD-to-binary converter.
package bcd_pkg;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        HOLD    = 2'd1,
        DRAIN   = 2'd2
    } state_t;

    localparam logic [7:0] ASCII_0     = 8'h30;
    localparam logic [7:0] ASCII_9     = 8'h39;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_BADCHAR = 2'b01;
    localparam logic [1:0] ERR_OVF     = 2'b10;

    localparam int unsigned NDIG_DEFAULT = 300;

endpackage

// File: rtl/ascii_digit_decode.sv
// Classifies an ASCII character as a decimal digit and extracts its BCD nibble.
module ascii_digit_decode
    import bcd_pkg::*;
(
    input  logic [7:0] char_data,
    output logic       is_digit,
    output logic [3:0] nibble
);

    always_comb begin
        is_digit = (char_data >= ASCII_0) && (char_data <= ASCII_9);
        nibble   = char_data[3:0];
    end

endmodule

// File: rtl/ascii_bcd_packer.sv
// Packs a framed ASCII decimal stream into a 4*NDIG-bit BCD vector; newest digit enters the top
// slot and older digits shift down, so short frames are zero-padded.
module ascii_bcd_packer
    import bcd_pkg::*;
#(
    parameter  int unsigned NDIG = NDIG_DEFAULT,
    localparam int unsigned CW   = $clog2(NDIG + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              char_valid,
    input  logic [7:0]        char_data,
    input  logic              char_last,
    output logic              char_ready,
    output logic [4*NDIG-1:0] bcd,
    output logic              bcd_valid,
    input  logic              bcd_ready,
    output logic [CW-1:0]     digit_count,
    output logic              err,
    output logic [1:0]        err_code
);

    state_t     state;
    logic       is_digit;
    logic [3:0] nibble;
    logic       accept;
    logic       full;

    ascii_digit_decode u_decode (
        .char_data (char_data),
        .is_digit  (is_digit),
        .nibble    (nibble)
    );

    // Ready depends only on the state register, so it drops as soon as a frame is held.
    assign char_ready = !reset && (state != HOLD);
    assign accept     = char_valid && char_ready;
    assign full       = (digit_count == CW'(NDIG));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= COLLECT;
            bcd         <= '0;
            bcd_valid   <= 1'b0;
            digit_count <= '0;
            err         <= 1'b0;
            err_code    <= ERR_NONE;
        end else begin
            err      <= 1'b0;
            err_code <= ERR_NONE;
            case (state)
                COLLECT: begin
                    if (accept) begin
                        if (!is_digit || full) begin
                            err         <= 1'b1;
                            err_code    <= is_digit ? ERR_OVF : ERR_BADCHAR;
                            bcd         <= '0;
                            digit_count <= '0;
                            state       <= char_last ? COLLECT : DRAIN;
                        end else begin
                            bcd         <= {nibble, bcd[4*NDIG-1:4]};
                            digit_count <= digit_count + CW'(1);
                            if (char_last) begin
                                bcd_valid <= 1'b1;
                                state     <= HOLD;
                            end
                        end
                    end
                end
                HOLD: begin
                    if (bcd_ready) begin
                        bcd         <= '0;
                        digit_count <= '0;
                        bcd_valid   <= 1'b0;
                        state       <= COLLECT;
                    end
                end
                DRAIN: begin
                    // Rest of a faulted frame is swallowed silently.
                    if (accept && char_last) begin
                        bcd         <= '0;
                        digit_count <= '0;
                        state       <= COLLECT;
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end

endmodule
